// File: rtl/bank_out_arbiter_if.sv
// Packet types and the request/output bundle for bank_out_arbiter.
// The slave modport is the arbiter side; the master modport is the node/router side.
`timescale 1ns/1ps

package bank_out_arbiter_pkg;
    typedef enum logic [1:0] {
        CTRL_PATH  = 2'd0,
        CTRL_SUM   = 2'd1,
        CTRL_RSVD2 = 2'd2,
        CTRL_RSVD3 = 2'd3
    } ctrl_e;

    typedef struct packed {
        ctrl_e       ctrl;
        logic [7:0]  addr;
        logic [15:0] data;
    } pkt_t;
endpackage

interface bank_out_arbiter_if
    import bank_out_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) ();
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    pkt_t               req_pkt [NUM_REQ];
    logic               out_valid;
    logic               out_ready;
    pkt_t               out_pkt;
    logic [IDX_W-1:0]   out_src;

    modport master (
        output req_valid, req_pkt, out_ready,
        input  req_ready, out_valid, out_pkt, out_src
    );

    modport slave (
        input  req_valid, req_pkt, out_ready,
        output req_ready, out_valid, out_pkt, out_src
    );
endinterface

// File: rtl/bank_out_arbiter.sv
// Round-robin arbiter feeding a one-entry registered output stage.
// Optional macro ARB_SUM_PRIORITY_EN: CTRL_SUM packets win over all other requests.
`timescale 1ns/1ps

module bank_out_arbiter
    import bank_out_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    bank_out_arbiter_if.slave bus
);

    logic               r_outValid;
    pkt_t               r_outPkt;
    logic [IDX_W-1:0]   r_outSrc;
    logic [IDX_W-1:0]   r_ptr;

    logic               w_loadEn;
    logic [NUM_REQ-1:0] w_eligible;
    logic [IDX_W-1:0]   w_winner;
    logic               w_found;
    logic [IDX_W:0]     w_sum;
    logic [NUM_REQ-1:0] w_reqReady;
    logic [IDX_W-1:0]   w_ptrNext;

    assign w_loadEn = !r_outValid || bus.out_ready;

`ifdef ARB_SUM_PRIORITY_EN
    logic [NUM_REQ-1:0] w_sumValid;

    always_comb begin
        w_sumValid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sumValid[i] = bus.req_valid[i] && (bus.req_pkt[i].ctrl == CTRL_SUM);
        end
    end

    assign w_eligible = (|w_sumValid) ? w_sumValid : bus.req_valid;
`else
    assign w_eligible = bus.req_valid;
`endif

    // Scan from the farthest offset down so the offset closest to r_ptr wins; wrap is an explicit modulo.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_sum    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            if (w_eligible[w_sum[IDX_W-1:0]]) begin
                w_winner = w_sum[IDX_W-1:0];
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_reqReady = '0;
        if (rst && w_loadEn && w_found) begin
            w_reqReady = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
        end
    end

    assign w_ptrNext = (w_winner == IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outValid <= 1'b0;
            r_outPkt   <= '0;
            r_outSrc   <= '0;
            r_ptr      <= '0;
        end else if (w_loadEn && w_found) begin
            r_outValid <= 1'b1;
            r_outPkt   <= bus.req_pkt[w_winner];
            r_outSrc   <= w_winner;
            r_ptr      <= w_ptrNext;
        end else if (r_outValid && bus.out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign bus.req_ready = w_reqReady;
    assign bus.out_valid = r_outValid;
    assign bus.out_pkt   = r_outPkt;
    assign bus.out_src   = r_outSrc;

endmodule
